// File: rtl/video_timing_if.sv
// Raster timing bundle from video_timing_gen to the framebuffer fetch and the DVI encoder.
// The widths must match the XW/YW that the generator derives from its totals.
`timescale 1ns/1ps
interface video_timing_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);
  logic          running_o;
  logic          hsync_o;
  logic          vsync_o;
  logic          de_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
  logic          line_start_o;
  logic          frame_start_o;

  modport master (
    output running_o, hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
  );

  modport slave (
    input running_o, hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator for the pixel-clock domain: waits for stable PLL lock, then produces
// registered hsync/vsync/de/x/y and line/frame start pulses with one cycle of latency.
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW         = $clog2(H_TOTAL),
  localparam int unsigned YW         = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pll_locked_i,
  video_timing_if.master vid
);

  localparam int unsigned LCW      = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  typedef enum logic [0:0] {StWaitLock, StRun} state_e;

  state_e          state_q, state_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [XW-1:0]   h_q, h_d;
  logic [YW-1:0]   v_q, v_d;

  logic            running_q, running_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;

  logic [31:0]     h32, v32;
  logic            active;

  assign h32 = 32'(h_q);
  assign v32 = 32'(v_q);

  // State, counters and the registered raster outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StWaitLock;
      lock_cnt_q    <= '0;
      h_q           <= '0;
      v_q           <= '0;
      running_q     <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      h_q           <= h_d;
      v_q           <= v_d;
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    h_d        = h_q;
    v_d        = v_q;
    unique case (state_q)
      StWaitLock: begin
        h_d = '0;
        v_d = '0;
        if (!pll_locked_i) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          state_d    = StRun;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      StRun: begin
        // Loss of lock overrides any wrap and abandons the partial frame.
        if (!pll_locked_i) begin
          state_d    = StWaitLock;
          lock_cnt_d = '0;
          h_d        = '0;
          v_d        = '0;
        end else if (h32 == H_TOTAL - 1) begin
          h_d = '0;
          v_d = (v32 == V_TOTAL - 1) ? '0 : v_q + YW'(1);
        end else begin
          h_d = h_q + XW'(1);
        end
      end
    endcase
  end

  // Outputs go idle on the same edge that sees lock drop, so nothing past the drop is shown.
  always_comb begin
    active        = (state_q == StRun) && pll_locked_i;
    running_d     = active;
    de_d          = active && (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    hsync_d       = (active && (h32 >= HS_START) && (h32 < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = (active && (v32 >= VS_START) && (v32 < VS_END)) ? VS_POL : ~VS_POL;
    x_d           = active ? h_q : '0;
    y_d           = active ? v_q : '0;
    line_start_d  = active && (h_q == '0);
    frame_start_d = active && (h_q == '0) && (v_q == '0);
  end

  assign vid.running_o     = running_q;
  assign vid.hsync_o       = hsync_q;
  assign vid.vsync_o       = vsync_q;
  assign vid.de_o          = de_q;
  assign vid.x_o           = x_q;
  assign vid.y_o           = y_q;
  assign vid.line_start_o  = line_start_q;
  assign vid.frame_start_o = frame_start_q;

endmodule
